// File: rtl/ber_sync_ctrl_pkg.sv
// Shared definitions for the BER synchronization controller and the uBlaze register map.
package ber_sync_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SYNC  = 2'b01,
        ST_COUNT = 2'b10
    } sync_state_t;

    localparam int PRBS_MAX_CYCLES_DEF = 511;
    localparam int BITS_PER_ADDR_DEF   = 255;

endpackage

// File: rtl/ber_sync_ctrl_sync_window_cnt.sv
// Candidate-window counters: bit_cnt walks one window, addr_idx walks the candidate list.
module sync_window_cnt #(
    parameter int PRBS_MAX_CYCLES = 511,
    parameter int BITS_PER_ADDR   = 255,
    localparam int BCW = $clog2(BITS_PER_ADDR + 1),
    localparam int AW  = $clog2(PRBS_MAX_CYCLES)
) (
    input  logic           clk,
    input  logic           i_reset_n,
    input  logic           i_clr,
    input  logic           i_step,
    output logic [BCW-1:0] o_bit_cnt,
    output logic [AW-1:0]  o_addr_idx,
    output logic           o_win_last,
    output logic           o_sweep_last
);

    logic [BCW-1:0] r_bit_cnt;
    logic [AW-1:0]  r_addr_idx;
    logic           w_win_last;
    logic           w_sweep_last;

    assign w_win_last   = (r_bit_cnt == BCW'(BITS_PER_ADDR));
    assign w_sweep_last = (r_addr_idx == AW'(PRBS_MAX_CYCLES - 1));

    // addr_idx saturates on the last candidate so it never wraps past the tap range
    always_ff @(posedge clk) begin
        if (!i_reset_n || i_clr) begin
            r_bit_cnt  <= '0;
            r_addr_idx <= '0;
        end else if (i_step) begin
            if (w_win_last) begin
                r_bit_cnt <= '0;
                if (!w_sweep_last)
                    r_addr_idx <= r_addr_idx + AW'(1);
            end else begin
                r_bit_cnt <= r_bit_cnt + BCW'(1);
            end
        end
    end

    assign o_bit_cnt    = r_bit_cnt;
    assign o_addr_idx   = r_addr_idx;
    assign o_win_last   = w_win_last;
    assign o_sweep_last = w_sweep_last;

endmodule

// File: rtl/ber_sync_ctrl.sv
// BER synchronization controller: sweeps PRBS candidate latencies, then enables BER counting.
module ber_sync_ctrl
    import ber_sync_ctrl_pkg::*;
#(
    parameter int PRBS_MAX_CYCLES = PRBS_MAX_CYCLES_DEF,
    parameter int BITS_PER_ADDR   = BITS_PER_ADDR_DEF
) (
    input  logic                               clk,
    input  logic                               i_reset_n,
    input  logic                               i_en_rx,
    input  logic                               i_ctrl,
    input  logic                               i_start,
    input  logic                               i_stop,
    output logic                               o_synchro_en,
    output logic                               o_prbs_cmp_curr_addr_done,
    output logic                               o_ber_counter_en,
    output logic                               o_ber_clr,
    output logic                               o_sync_done,
    output logic [1:0]                         o_state,
    output logic [$clog2(PRBS_MAX_CYCLES)-1:0] o_addr_idx
);

    localparam int BCW = $clog2(BITS_PER_ADDR + 1);

    sync_state_t    r_state;
    logic           r_synchro_en;
    logic           r_done;
    logic           r_ber_en;
    logic           r_ber_clr;
    logic           r_sync_done;

    logic           w_cnt_clr;
    logic           w_cnt_step;
    logic [BCW-1:0] w_bit_cnt;
    logic           w_win_last;
    logic           w_sweep_last;

    // Counters are cleared in the same edge the FSM lands in IDLE so o_addr_idx reads 0 at once
    assign w_cnt_clr  = !i_en_rx || (r_state == ST_IDLE) || (i_ctrl && i_stop);
    assign w_cnt_step = i_en_rx && i_ctrl && !i_stop && (r_state == ST_SYNC);

    sync_window_cnt #(
        .PRBS_MAX_CYCLES (PRBS_MAX_CYCLES),
        .BITS_PER_ADDR   (BITS_PER_ADDR)
    ) u_win_cnt (
        .clk          (clk),
        .i_reset_n    (i_reset_n),
        .i_clr        (w_cnt_clr),
        .i_step       (w_cnt_step),
        .o_bit_cnt    (w_bit_cnt),
        .o_addr_idx   (o_addr_idx),
        .o_win_last   (w_win_last),
        .o_sweep_last (w_sweep_last)
    );

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            r_state      <= ST_IDLE;
            r_synchro_en <= 1'b0;
            r_done       <= 1'b0;
            r_ber_en     <= 1'b0;
            r_ber_clr    <= 1'b0;
            r_sync_done  <= 1'b0;
        end else begin
            r_ber_clr <= 1'b0;
            if (!i_en_rx) begin
                r_state      <= ST_IDLE;
                r_synchro_en <= 1'b0;
                r_done       <= 1'b0;
                r_ber_en     <= 1'b0;
                r_sync_done  <= 1'b0;
            end else if (i_ctrl) begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (i_start && !i_stop) begin
                            r_state      <= ST_SYNC;
                            r_synchro_en <= 1'b1;
                            r_done       <= 1'b0;
                            r_ber_clr    <= 1'b1;
                        end
                    end
                    ST_SYNC: begin
                        if (i_stop) begin
                            r_state      <= ST_IDLE;
                            r_synchro_en <= 1'b0;
                            r_done       <= 1'b0;
                            r_sync_done  <= 1'b0;
                        end else if (w_win_last && w_sweep_last) begin
                            r_state      <= ST_COUNT;
                            r_synchro_en <= 1'b0;
                            r_done       <= 1'b0;
                            r_ber_en     <= 1'b1;
                            r_sync_done  <= 1'b1;
                        end else begin
                            // done is raised one strobe ahead so it covers the window's final symbol
                            r_done <= (w_bit_cnt == BCW'(BITS_PER_ADDR - 1));
                        end
                    end
                    ST_COUNT: begin
                        if (i_stop) begin
                            r_state     <= ST_IDLE;
                            r_ber_en    <= 1'b0;
                            r_sync_done <= 1'b0;
                        end
                    end
                    default: begin
                        r_state      <= ST_IDLE;
                        r_synchro_en <= 1'b0;
                        r_done       <= 1'b0;
                        r_ber_en     <= 1'b0;
                        r_sync_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_synchro_en              = r_synchro_en;
    assign o_prbs_cmp_curr_addr_done = r_done;
    assign o_ber_counter_en          = r_ber_en;
    assign o_ber_clr                 = r_ber_clr;
    assign o_sync_done               = r_sync_done;
    assign o_state                   = r_state;

endmodule

// File: tb/tb_ber_sync_ctrl.sv
// Scoreboard bench for ber_sync_ctrl with PRBS_MAX_CYCLES=7, BITS_PER_ADDR=4, i_ctrl every 4 clk.
module tb_ber_sync_ctrl;

    localparam int P = 7;
    localparam int B = 4;

    logic       clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_en_rx = 1'b1;
    logic       i_ctrl = 1'b0;
    logic       i_start = 1'b0;
    logic       i_stop = 1'b0;
    logic       o_synchro_en, o_prbs_cmp_curr_addr_done, o_ber_counter_en;
    logic       o_ber_clr, o_sync_done;
    logic [1:0] o_state;
    logic [2:0] o_addr_idx;

    typedef struct packed {
        logic [1:0] st;
        logic       syn;
        logic       done;
        logic       ben;
        logic       clr;
        logic       sdone;
        logic [2:0] addr;
    } exp_t;

    typedef struct {
        int    tag;
        exp_t  e;
        string nm;
    } item_t;

    item_t sbq[$];
    int    cyc = 0;
    int    n_cmp = 0;
    int    n_err = 0;

    ber_sync_ctrl #(.PRBS_MAX_CYCLES(P), .BITS_PER_ADDR(B)) dut (
        .clk                       (clk),
        .i_reset_n                 (i_reset_n),
        .i_en_rx                   (i_en_rx),
        .i_ctrl                    (i_ctrl),
        .i_start                   (i_start),
        .i_stop                    (i_stop),
        .o_synchro_en              (o_synchro_en),
        .o_prbs_cmp_curr_addr_done (o_prbs_cmp_curr_addr_done),
        .o_ber_counter_en          (o_ber_counter_en),
        .o_ber_clr                 (o_ber_clr),
        .o_sync_done               (o_sync_done),
        .o_state                   (o_state),
        .o_addr_idx                (o_addr_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic p_ctrl = 1'b0, p_rst = 1'b0, p_en = 1'b1;
    always @(posedge clk) begin
        p_ctrl <= i_ctrl;
        p_rst  <= i_reset_n;
        p_en   <= i_en_rx;
    end

    function automatic exp_t mk(input logic [1:0] st, input logic syn, input logic done,
                                input logic ben, input logic clr, input logic sdone,
                                input logic [2:0] addr);
        exp_t e;
        e.st = st; e.syn = syn; e.done = done; e.ben = ben;
        e.clr = clr; e.sdone = sdone; e.addr = addr;
        return e;
    endfunction

    // Monitor: pops expected records due at this edge, plus the enable invariants
    logic [2:0] pv = 3'b000;
    exp_t       act;
    item_t      it;
    bit         ok;
    always @(negedge clk) begin
        act = mk(o_state, o_synchro_en, o_prbs_cmp_curr_addr_done, o_ber_counter_en,
                 o_ber_clr, o_sync_done, o_addr_idx);
        while (sbq.size() > 0 && sbq[0].tag <= cyc) begin
            it = sbq.pop_front();
            n_cmp++;
            if (it.tag != cyc || act !== it.e) begin
                n_err++;
                $display("FAIL %s @cyc %0d: got st=%b syn=%b done=%b ben=%b clr=%b sdone=%b addr=%0d, want st=%b syn=%b done=%b ben=%b clr=%b sdone=%b addr=%0d",
                         it.nm, cyc, act.st, act.syn, act.done, act.ben, act.clr, act.sdone, act.addr,
                         it.e.st, it.e.syn, it.e.done, it.e.ben, it.e.clr, it.e.sdone, it.e.addr);
            end
        end
        ok = !(o_synchro_en && o_ber_counter_en) && !(o_prbs_cmp_curr_addr_done && !o_synchro_en);
        if ({o_synchro_en, o_prbs_cmp_curr_addr_done, o_ber_counter_en} !== pv
            && !(p_ctrl || !p_rst || !p_en))
            ok = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL invariant @cyc %0d: syn/done/ben now %b prev %b, ctrl at edge %b",
                     cyc, {o_synchro_en, o_prbs_cmp_curr_addr_done, o_ber_counter_en}, pv, p_ctrl);
        end
        pv = {o_synchro_en, o_prbs_cmp_curr_addr_done, o_ber_counter_en};
    end

    task automatic tick(input logic ctrl, input bit chk, input exp_t e, input string nm);
        item_t q;
        i_ctrl = ctrl;
        if (chk) begin
            q.tag = cyc + 1; q.e = e; q.nm = nm;
            sbq.push_back(q);
        end
        @(posedge clk); #1;
        i_ctrl = 1'b0;
    endtask

    // One symbol: strobe clk then three quiet clks; the last quiet clk re-checks stability
    task automatic sym(input bit chk, input exp_t e, input string nm);
        exp_t h;
        h = e; h.clr = 1'b0;
        tick(1'b1, chk, e, nm);
        i_start = 1'b0; i_stop = 1'b0;
        tick(1'b0, 1'b0, e, nm);
        tick(1'b0, 1'b0, e, nm);
        tick(1'b0, chk, h, {nm, "_hold"});
    endtask

    task automatic start_sync();
        i_start = 1'b1;
        sym(1'b1, mk(2'b01, 1, 0, 0, 1, 0, 3'd0), "sync_entry");
    endtask

    // Strobes 1..upto after SYNC entry; done on every 5th, COUNT after the 35th
    task automatic sweep(input int upto);
        for (int k = 1; k <= upto; k++) begin
            if (k == P * (B + 1))
                sym(1'b1, mk(2'b10, 0, 0, 1, 0, 1, 3'(P - 1)), "count_entry");
            else
                sym(1'b1, mk(2'b01, 1, (k % (B + 1)) == B, 0, 0, 0, 3'(k / (B + 1))), "sync_strobe");
        end
    endtask

    exp_t zero;
    exp_t cnt;
    initial begin
        zero = mk(2'b00, 0, 0, 0, 0, 0, 3'd0);
        cnt  = mk(2'b10, 0, 0, 1, 0, 1, 3'd6);

        tick(1'b0, 1'b0, zero, "");
        tick(1'b1, 1'b1, zero, "reset_state");
        i_reset_n = 1'b1;
        tick(1'b0, 1'b1, zero, "idle_after_reset");
        i_start = 1'b1;
        tick(1'b0, 1'b1, zero, "start_without_strobe");

        // full sweep into COUNT, start ignored, stop returns to IDLE
        start_sync();
        sweep(P * (B + 1));
        i_start = 1'b1;
        sym(1'b1, cnt, "count_start_ignored");
        sym(1'b1, cnt, "count_held");
        i_stop = 1'b1;
        sym(1'b1, zero, "count_stop");

        // stop at strobe 12 of SYNC
        start_sync();
        sweep(11);
        i_stop = 1'b1;
        sym(1'b1, zero, "sync_stop");
        sym(1'b1, zero, "idle_after_stop");

        // start and stop together in IDLE
        i_start = 1'b1; i_stop = 1'b1;
        sym(1'b1, zero, "start_stop_idle");

        // start during SYNC is ignored
        start_sync();
        i_start = 1'b1;
        sym(1'b1, mk(2'b01, 1, 0, 0, 0, 0, 3'd0), "sync_start_ignored");
        i_stop = 1'b1;
        sym(1'b1, zero, "sync_stop2");

        // i_en_rx drop for one clk in COUNT, off the strobe
        start_sync();
        sweep(P * (B + 1));
        tick(1'b1, 1'b1, cnt, "count_before_drop");
        i_en_rx = 1'b0;
        tick(1'b0, 1'b1, zero, "en_rx_drop");
        i_en_rx = 1'b1;
        tick(1'b0, 1'b1, zero, "en_rx_restored");
        tick(1'b0, 1'b0, zero, "");
        sym(1'b1, zero, "idle_after_en_rx");

        // reset mid-sweep at addr 3, then a full fresh sweep
        start_sync();
        sweep(3 * (B + 1) + 1);
        tick(1'b0, 1'b1, mk(2'b01, 1, 0, 0, 0, 0, 3'd3), "addr3_reached");
        i_reset_n = 1'b0;
        tick(1'b0, 1'b1, zero, "reset_mid_sweep");
        i_reset_n = 1'b1;
        tick(1'b0, 1'b0, zero, "");
        tick(1'b0, 1'b0, zero, "");
        start_sync();
        sweep(P * (B + 1));
        i_stop = 1'b1;
        sym(1'b1, zero, "final_stop");

        tick(1'b0, 1'b0, zero, "");
        tick(1'b0, 1'b0, zero, "");
        if (sbq.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
